// File: rtl/aes_encryption_round_if.sv
// Request/response bundle between the AES round controller (master) and the
// single-round encryption engine (slave).
interface aes_encryption_round_if;
    logic         start_in;
    logic [3:0]   round_in;
    logic [127:0] key_in;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic         ready_out;
    logic         error_out;
    logic         busy_out;

    modport master (
        output start_in, round_in, key_in, data_in,
        input  data_out, ready_out, error_out, busy_out
    );

    modport slave (
        input  start_in, round_in, key_in, data_in,
        output data_out, ready_out, error_out, busy_out
    );
endinterface

// File: rtl/aes_encryption_round.sv
// Iterative single-round AES-128 encryption engine: one round per start,
// with the S-box and MixColumns paths combinational from the state register.

module sbox_combi (
    input  logic       en_or_de,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] inv_fwd;
    logic [7:0] pre_inv;

    always_comb begin
        inv_fwd = gf_inv(din);
        pre_inv = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
        if (en_or_de) begin
            dout = inv_fwd ^ rotl(inv_fwd, 1) ^ rotl(inv_fwd, 2) ^ rotl(inv_fwd, 3)
                 ^ rotl(inv_fwd, 4) ^ 8'h63;
        end else begin
            dout = gf_inv(pre_inv);
        end
    end
endmodule

module aes_mixcolumn (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        col_out[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        col_out[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        col_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        col_out[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

// state         | meaning
// IDLE          | waiting for start_in; round index captured on start
// LOAD          | capture data_in/key_in; reject round > LAST_ROUND
// SUB_SHIFT     | state <= ShiftRows(SubBytes(state))
// MIX_COLUMN    | state <= MixColumns(state)
// ADD_ROUND_KEY | data_out <= state ^ key, pulse ready_out
module aes_encryption_round #(
    parameter int LAST_ROUND = 10
) (
    input logic                  clk,
    input logic                  reset,
    aes_encryption_round_if.slave bus
);
    localparam logic [2:0] IDLE          = 3'd0;
    localparam logic [2:0] LOAD          = 3'd1;
    localparam logic [2:0] SUB_SHIFT     = 3'd2;
    localparam logic [2:0] MIX_COLUMN    = 3'd3;
    localparam logic [2:0] ADD_ROUND_KEY = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dout_q, dout_d;
    logic         ready_q, ready_d;
    logic         error_q, error_d;

    logic [127:0] sub_bytes;
    logic [127:0] sub_shift;
    logic [127:0] mix_cols;
    logic         round_valid;
    logic         round_last;

    // column c lives at [127-32c -: 32], row 0 is the top byte of a column
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            sbox_combi u_sbox (
                .en_or_de (1'b1),
                .din      (blk_q[127-32*c-8*r -: 8]),
                .dout     (sub_bytes[127-32*c-8*r -: 8])
            );
            assign sub_shift[127-32*c-8*r -: 8] = sub_bytes[127-32*((c+r)%4)-8*r -: 8];
        end
        aes_mixcolumn u_mix (
            .col_in  (blk_q[127-32*c -: 32]),
            .col_out (mix_cols[127-32*c -: 32])
        );
    end

    assign round_valid = (round_q <= 4'(LAST_ROUND));
    assign round_last  = (round_q == 4'(LAST_ROUND));

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;
        key_d   = key_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    round_d = bus.round_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                blk_d = bus.data_in;
                key_d = bus.key_in;
                if (!round_valid) begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (round_q == 4'd0) begin
                    state_d = ADD_ROUND_KEY;
                end else begin
                    state_d = SUB_SHIFT;
                end
            end
            SUB_SHIFT: begin
                blk_d   = sub_shift;
                state_d = round_last ? ADD_ROUND_KEY : MIX_COLUMN;
            end
            MIX_COLUMN: begin
                blk_d   = mix_cols;
                state_d = ADD_ROUND_KEY;
            end
            ADD_ROUND_KEY: begin
                dout_d  = blk_q ^ key_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            blk_q   <= 128'd0;
            key_q   <= 128'd0;
            dout_q  <= 128'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.ready_out = ready_q;
    assign bus.error_out = error_q;
    assign bus.busy_out  = (state_q != IDLE);
endmodule
